bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Round-robin arbiter that owns the `bus_grant` lines of the shared tri-state data bus. Each `data_bus_device` on the bus raises a request; the arbiter issues a one-hot registered grant, bounds each owner's tenure, and inserts one all-idle turnaround cycle between owners so two drivers never overlap on `bus_data`/`bus_valid`. It replaces the manually driven grant inputs used for bring-up.

## Interface
- `N_DEV`, default 4: number of bus devices; legal range 2–8.
- `MAX_TENURE`, default 16: maximum consecutive cycles one grant may be held; legal range 2–255.
- `clk` input, 1 bit: single clock; all logic on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset. This is the only clock and reset.
- `bus_req` input, `N_DEV` bits: request per device; level-sensitive; held high while the device wants the bus.
- `bus_done` input, `N_DEV` bits: release pulse from the current owner; ignored for non-owners.
- `bus_grant` output, `N_DEV` bits: one-hot or all-zero, registered; drives each device's `bus_grant`.
- `grant_id` output, `$clog2(N_DEV)` bits: index of the current owner; 0 when no grant is active.
- `grant_active` output, 1 bit: OR of `bus_grant`.
- `tenure_expired` output, 1 bit: one-cycle pulse when a grant is revoked by tenure timeout.

## Operation
- States:
  - IDLE: no grant.
  - GRANT: one owner.
  - TURNAROUND: no grant; one cycle only.
- Reset: state IDLE, all outputs 0, tenure counter 0, round-robin pointer 0 (device 0 highest priority).
- Arbitration in IDLE or TURNAROUND:
  - Search `bus_req` starting at the pointer and wrapping modulo `N_DEV`; the first set bit wins.
  - If a winner exists, the next state is GRANT, `bus_grant` = one-hot(winner), and the pointer is set to winner+1 (wrapping).
  - If there is no request, the next state is IDLE.
- The pointer updates only on a new grant, so the most recent owner becomes lowest priority.
- GRANT release: any of these ends the grant:
  - `bus_done[owner]`=1;
  - `bus_req[owner]`=0;
  - tenure counter = `MAX_TENURE`-1.
- On release, the next state is TURNAROUND and `bus_grant` clears on the same edge.
- Tenure counter:
  - Clears on grant entry and increments every GRANT cycle.
  - 8 bits wide; saturation is unreachable because expiry forces exit.
- `tenure_expired` pulses only when the exit cause is expiry and neither `bus_done` nor a dropped request applies.
- TURNAROUND always lasts exactly one cycle and arbitrates during that cycle. There is never a direct owner-to-owner switch.
- If the expired owner is the only requester, it is re-granted after turnaround.
- A `bus_done` from a non-owner has no effect.
- Requests rising during GRANT are not considered until TURNAROUND.
- `rst` asserted in any state returns to reset values on the next edge. The grant drops immediately, with no turnaround.

## Timing
- Request latency from IDLE: `bus_req` high at edge t gives `bus_grant` high from edge t+1.
- Release: `bus_done` or request drop at edge t gives `bus_grant` low from edge t+1.
- Handover: grant low for exactly 1 cycle (TURNAROUND), then the next owner's grant from edge t+2.
- Maximum hold: a grant is high for at most `MAX_TENURE` consecutive cycles.
- Worst-case wait for a requester holding `bus_req` high: (`N_DEV`-1)×(`MAX_TENURE`+1) cycles after its request is first seen in an arbitration cycle.
- `grant_id` and `grant_active` change on the same edges as `bus_grant`.
- `tenure_expired` is high during the first TURNAROUND cycle after a timeout.

## Structure
- Shared package `bus_pkg`:
  - `BUS_N_DEV` default and `BUS_ID_W`;
  - arbiter state enum `{ARB_IDLE, ARB_GRANT, ARB_TURN}`;
  - default `BUS_MAX_TENURE`.
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: `req[N]`, `ptr`.
  - Outputs: `found`, `idx`, `onehot`.
  - Instantiated once; all state stays in `bus_arbiter`.

## Test plan
- Reset, then `bus_req`=0001 at edge 5 → `bus_grant`=0001 and `grant_id`=0 from edge 6. `bus_done[0]` at edge 9 → grant 0000 from edge 10, state IDLE at edge 11.
- `bus_req`=1111 held high with no `bus_done`, `MAX_TENURE`=4 → grants 0001, 0010, 0100, 1000, 0001, each high 4 cycles, separated by one 0000 cycle, with `tenure_expired` pulsing each gap.
- Owner 2 drops `bus_req` mid-tenure while `bus_req[3]` is high → next edge grant 0000, following edge grant 1000. `tenure_expired` stays 0.
- `bus_done[1]` pulsed while device 0 owns the bus → no effect; device 0 keeps the grant until its own release.
- Single requester device 3 with `MAX_TENURE`=4 → grant high 4 cycles, 0000 for 1 cycle, high again; `tenure_expired` pulses each gap.
- `rst` asserted during GRANT → next edge all outputs 0 and pointer 0. `bus_req`=1010 afterwards → device 1 granted first.

Source files
------------

// File: rtl/bus_pkg.sv
// bus_pkg: shared constants and arbiter state encoding for the tri-state data bus
package bus_pkg;
    localparam int BUS_N_DEV      = 4;
    localparam int BUS_ID_W       = $clog2(BUS_N_DEV);
    localparam int BUS_MAX_TENURE = 16;
    typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_TURN} arb_state_t;
endpackage

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: request/release/grant signals between the arbiter and the bus devices
interface bus_arbiter_if import bus_pkg::*; #(
    parameter int N_DEV = BUS_N_DEV
);
    localparam int ID_W = $clog2(N_DEV);
    logic [N_DEV-1:0] bus_req;
    logic [N_DEV-1:0] bus_done;
    logic [N_DEV-1:0] bus_grant;
    logic [ID_W-1:0]  grant_id;
    logic             grant_active;
    logic             tenure_expired;
    modport master (
        input  bus_req, bus_done,
        output bus_grant, grant_id, grant_active, tenure_expired
    );
    modport slave (
        output bus_req, bus_done,
        input  bus_grant, grant_id, grant_active, tenure_expired
    );
endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search of req starting at ptr, wrapping modulo N
module rr_pick import bus_pkg::*; #(
    parameter int N = BUS_N_DEV,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx,
    output logic [N-1:0] onehot
);
    // scan from farthest to nearest offset so the nearest request to ptr is left in idx
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % N]) begin
                found = 1'b1;
                idx   = W'((int'(ptr) + i) % N);
            end
        end
    end
    assign onehot = found ? (N'(1) << idx) : '0;
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin bus grant with bounded tenure and a one-cycle turnaround between owners
module bus_arbiter import bus_pkg::*; #(
    parameter int N_DEV      = BUS_N_DEV,
    parameter int MAX_TENURE = BUS_MAX_TENURE
) (
    input  logic          clk,
    input  logic          rst,
    bus_arbiter_if.master bus
);
    localparam int ID_W = $clog2(N_DEV);
    arb_state_t       state, state_nx;
    logic [N_DEV-1:0] grant, grant_nx, pick_onehot;
    logic [ID_W-1:0]  owner, owner_nx, ptr, ptr_nx, pick_idx, next_ptr;
    logic [7:0]       tenure, tenure_nx;
    logic             expired, expired_nx, pick_found, user_release, timeout;

    rr_pick #(.N(N_DEV), .W(ID_W)) u_pick (
        .req    (bus.bus_req),
        .ptr    (ptr),
        .found  (pick_found),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    assign user_release = bus.bus_done[owner] | ~bus.bus_req[owner];
    assign timeout      = tenure == 8'(MAX_TENURE - 1);
    assign next_ptr     = (pick_idx == ID_W'(N_DEV - 1)) ? '0 : pick_idx + ID_W'(1);

    // next state: arbitrate when nobody owns the bus, otherwise watch for release or timeout
    always_comb begin
        state_nx   = state;
        grant_nx   = grant;
        owner_nx   = owner;
        ptr_nx     = ptr;
        tenure_nx  = tenure;
        expired_nx = 1'b0;
        case (state)
            ARB_GRANT: begin
                if (user_release || timeout) begin
                    state_nx   = ARB_TURN;
                    grant_nx   = '0;
                    owner_nx   = '0;
                    expired_nx = ~user_release;
                end else begin
                    tenure_nx = tenure + 8'd1;
                end
            end
            default: begin
                state_nx  = pick_found ? ARB_GRANT : ARB_IDLE;
                grant_nx  = pick_onehot;
                owner_nx  = pick_found ? pick_idx : '0;
                ptr_nx    = pick_found ? next_ptr : ptr;
                tenure_nx = '0;
            end
        endcase
    end

    // state and registered outputs; reset drops the grant at once with no turnaround
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ARB_IDLE;
            grant   <= '0;
            owner   <= '0;
            ptr     <= '0;
            tenure  <= '0;
            expired <= 1'b0;
        end else begin
            state   <= state_nx;
            grant   <= grant_nx;
            owner   <= owner_nx;
            ptr     <= ptr_nx;
            tenure  <= tenure_nx;
            expired <= expired_nx;
        end
    end

    assign bus.bus_grant      = grant;
    assign bus.grant_id       = owner;
    assign bus.grant_active   = |grant;
    assign bus.tenure_expired = expired;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed stimulus with a cycle-level reference model and literal spot checks
module tb_bus_arbiter;
    import bus_pkg::*;
    localparam int N  = 4;
    localparam int MT = 4;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    bus_arbiter_if #(.N_DEV(N)) bus ();
    bus_arbiter #(.N_DEV(N), .MAX_TENURE(MT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // reference model: who owns the bus and for how many cycles, updated from the inputs seen at each edge
    int   m_owner = -1;
    int   m_ptr   = 0;
    int   m_held  = 0;
    bit   m_exp   = 1'b0;
    bit   m_valid = 1'b0;
    logic [N-1:0] s_req, s_done, e_grant;
    logic s_rst;

    always @(posedge clk) begin
        s_req  = bus.bus_req;
        s_done = bus.bus_done;
        s_rst  = rst;
        m_exp  = 1'b0;
        if (s_rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_held  = 0;
            m_valid = 1'b1;
        end else if (m_owner >= 0) begin
            if (s_done[m_owner] || !s_req[m_owner]) begin
                m_owner = -1;
            end else if (m_held == MT) begin
                m_owner = -1;
                m_exp   = 1'b1;
            end else begin
                m_held++;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (m_owner < 0 && s_req[(m_ptr + k) % N]) begin
                    m_owner = (m_ptr + k) % N;
                    m_held  = 1;
                end
            end
            if (m_owner >= 0) m_ptr = (m_owner + 1) % N;
        end
        #1;
        if (m_valid) begin
            e_grant = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
            chk("model_grant", 32'(bus.bus_grant), 32'(e_grant));
            chk("model_id", 32'(bus.grant_id), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
            chk("model_active", 32'(bus.grant_active), 32'(m_owner >= 0));
            chk("model_expired", 32'(bus.tenure_expired), 32'(m_exp));
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        bus.bus_req  = '0;
        bus.bus_done = '0;
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.bus_req  = '0;
        bus.bus_done = '0;
        step(3);
        chk("reset_grant", 32'(bus.bus_grant), 32'h0);
        chk("reset_id", 32'(bus.grant_id), 32'h0);
        chk("reset_expired", 32'(bus.tenure_expired), 32'h0);
        rst = 1'b0;
        step(1);
        // single request, released by done
        bus.bus_req = 4'b0001;
        step(1);
        chk("t1_grant", 32'(bus.bus_grant), 32'h1);
        chk("t1_id", 32'(bus.grant_id), 32'h0);
        chk("t1_active", 32'(bus.grant_active), 32'h1);
        step(1);
        bus.bus_done = 4'b0001;
        step(1);
        chk("t1_release", 32'(bus.bus_grant), 32'h0);
        chk("t1_release_exp", 32'(bus.tenure_expired), 32'h0);
        bus.bus_done = '0;
        bus.bus_req  = '0;
        step(2);
        chk("t1_idle", 32'(bus.bus_grant), 32'h0);
        // all requesting: rotation with tenure expiry
        do_reset();
        bus.bus_req = 4'b1111;
        step(1);
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < MT; c++) begin
                chk("t2_hold", 32'(bus.bus_grant), 32'(1 << (g % 4)));
                step(1);
            end
            chk("t2_gap", 32'(bus.bus_grant), 32'h0);
            chk("t2_gap_exp", 32'(bus.tenure_expired), 32'h1);
            step(1);
        end
        chk("t2_next", 32'(bus.bus_grant), 32'h2);
        // owner drops its request; a late request from device 3 waits for turnaround
        do_reset();
        bus.bus_req = 4'b0100;
        step(1);
        chk("t3_grant", 32'(bus.bus_grant), 32'h4);
        chk("t3_id", 32'(bus.grant_id), 32'h2);
        bus.bus_req = 4'b1100;
        step(1);
        chk("t3_keep", 32'(bus.bus_grant), 32'h4);
        bus.bus_req = 4'b1000;
        step(1);
        chk("t3_gap", 32'(bus.bus_grant), 32'h0);
        chk("t3_gap_exp", 32'(bus.tenure_expired), 32'h0);
        step(1);
        chk("t3_handover", 32'(bus.bus_grant), 32'h8);
        chk("t3_handover_id", 32'(bus.grant_id), 32'h3);
        // done from a non-owner is ignored
        do_reset();
        bus.bus_req = 4'b0001;
        step(1);
        bus.bus_done = 4'b0010;
        step(1);
        chk("t4_ignore", 32'(bus.bus_grant), 32'h1);
        bus.bus_done = 4'b0001;
        step(1);
        chk("t4_release", 32'(bus.bus_grant), 32'h0);
        chk("t4_release_exp", 32'(bus.tenure_expired), 32'h0);
        bus.bus_done = '0;
        bus.bus_req  = '0;
        // done coinciding with expiry suppresses the expiry pulse
        do_reset();
        bus.bus_req = 4'b0001;
        step(4);
        bus.bus_done = 4'b0001;
        step(1);
        chk("t5_done_at_expiry", 32'(bus.bus_grant), 32'h0);
        chk("t5_done_at_expiry_exp", 32'(bus.tenure_expired), 32'h0);
        bus.bus_done = '0;
        // lone requester gets re-granted after every timeout
        do_reset();
        bus.bus_req = 4'b1000;
        step(1);
        for (int g = 0; g < 2; g++) begin
            for (int c = 0; c < MT; c++) begin
                chk("t6_hold", 32'(bus.bus_grant), 32'h8);
                step(1);
            end
            chk("t6_gap", 32'(bus.bus_grant), 32'h0);
            chk("t6_gap_exp", 32'(bus.tenure_expired), 32'h1);
            step(1);
        end
        chk("t6_regrant", 32'(bus.bus_grant), 32'h8);
        // reset mid-grant clears everything including the pointer
        rst = 1'b1;
        step(1);
        chk("t7_rst_grant", 32'(bus.bus_grant), 32'h0);
        chk("t7_rst_active", 32'(bus.grant_active), 32'h0);
        rst = 1'b0;
        bus.bus_req = 4'b1010;
        step(1);
        chk("t7_first", 32'(bus.bus_grant), 32'h2);
        chk("t7_first_id", 32'(bus.grant_id), 32'h1);
        bus.bus_req = '0;
        step(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
